rvfpm_mem_ctrl: RTL and testbench



---
 rtl/rvfpm_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rvfpm_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_mem_ctrl.sv
// rvfpm_mem_ctrl: in-order FLW/FSW sequencer for the CORE-V-XIF memory interface.
// Entries are allocated at tail, issued at iss, completed at cmp and retired at head.
// Optional feature: define RVFPM_MEM_ID_CHECK_EN to check result ids (sticky id_err).
// mem_req packing (MSB..LSB): id, addr[31:0], mode[1:0], we, size[2:0], be, attr[1:0],
//                             wdata, last, spec
// mem_result packing (MSB..LSB): id, rdata, err, dbg
module rvfpm_mem_ctrl #(
   parameter int DEPTH       = 4,
   parameter int X_ID_WIDTH  = 4,
   parameter int X_MEM_WIDTH = 32,
   parameter int FLEN        = 32,
   localparam int PW    = $clog2(DEPTH + 1),
   localparam int REQ_W = X_ID_WIDTH + 32 + 2 + 1 + 3 + X_MEM_WIDTH/8 + 2 + X_MEM_WIDTH + 2,
   localparam int RES_W = X_ID_WIDTH + X_MEM_WIDTH + 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ls_valid,
   output logic                   ls_ready,
   input  logic [X_ID_WIDTH-1:0]  ls_id,
   input  logic                   ls_we,
   input  logic [31:0]            ls_addr,
   input  logic [FLEN-1:0]        ls_wdata,
   input  logic [4:0]             ls_rd,
   input  logic [1:0]             ls_mode,
   input  logic                   kill,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [REQ_W-1:0]       mem_req,
   input  logic                   mem_result_valid,
   input  logic [RES_W-1:0]       mem_result,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [4:0]             wb_rd,
   output logic [FLEN-1:0]        wb_data,
   output logic [X_ID_WIDTH-1:0]  wb_id,
   output logic                   err_valid,
   output logic [X_ID_WIDTH-1:0]  err_id,
   output logic                   id_err,
   output logic [PW-1:0]          outstanding
);

   localparam int AW  = $clog2(DEPTH);
   localparam int BEW = X_MEM_WIDTH / 8;
   localparam logic [2:0] SIZE_WORD = 3'b010;

   // entry states
   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_PEND   = 2'd1;
   localparam logic [1:0] ST_ISSUED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // pointers carry one extra wrap bit so full and empty are distinguishable
   logic [PW-1:0] tail, iss, cmp, head;
   logic [AW-1:0] ti, ii, ci, hi;

   logic [1:0]            e_st    [DEPTH];
   logic [X_ID_WIDTH-1:0] e_id    [DEPTH];
   logic                  e_we    [DEPTH];
   logic [31:0]           e_addr  [DEPTH];
   logic [FLEN-1:0]       e_wdata [DEPTH];
   logic [4:0]            e_rd    [DEPTH];
   logic [1:0]            e_mode  [DEPTH];
   logic [FLEN-1:0]       e_rdata [DEPTH];
   logic                  e_err   [DEPTH];

   logic                  full, alloc, issue, compl, head_done, retire;
   logic [X_ID_WIDTH-1:0] res_id;
   logic [FLEN-1:0]       res_rdata;
   logic                  res_err;

   assign ti = tail[AW-1:0];
   assign ii = iss[AW-1:0];
   assign ci = cmp[AW-1:0];
   assign hi = head[AW-1:0];

   assign res_id    = mem_result[RES_W-1 -: X_ID_WIDTH];
   assign res_rdata = mem_result[FLEN+1:2];
   assign res_err   = mem_result[1];

   // full is based on registered pointers only: a retire this cycle does not free a slot yet
   assign full        = (tail - head) == PW'(DEPTH);
   assign ls_ready    = !full;
   assign alloc       = ls_valid && ls_ready && !kill;
   assign mem_valid   = (iss != tail);
   assign issue       = mem_valid && mem_ready;
   // results with nothing in flight (e.g. left over from before a reset) are dropped
   assign compl       = mem_result_valid && (cmp != iss);
   assign head_done   = (head != cmp) && (e_st[hi] == ST_DONE);
   assign outstanding = tail - head;

   // retire decode: errors and stores leave immediately, loads wait for the register file
   assign err_valid = head_done && e_err[hi];
   assign wb_valid  = head_done && !e_err[hi] && !e_we[hi];
   assign retire    = head_done && (e_err[hi] || e_we[hi] || wb_ready);

   assign err_id  = err_valid ? e_id[hi]    : '0;
   assign wb_rd   = wb_valid  ? e_rd[hi]    : '0;
   assign wb_data = wb_valid  ? e_rdata[hi] : '0;
   assign wb_id   = wb_valid  ? e_id[hi]    : '0;

   // request payload comes straight from the entry at iss, so it holds while stalled
   assign mem_req = mem_valid ?
      {e_id[ii], e_addr[ii], e_mode[ii], e_we[ii], SIZE_WORD, {BEW{1'b1}}, 2'b00,
       X_MEM_WIDTH'(e_wdata[ii]), 1'b1, 1'b0} : '0;

   // pointer updates; kill rewinds tail onto the issue point, keeping a handshaking entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tail <= '0;
         iss  <= '0;
         cmp  <= '0;
         head <= '0;
      end else begin
         if (kill)       tail <= issue ? iss + PW'(1) : iss;
         else if (alloc) tail <= tail + PW'(1);
         if (issue)  iss  <= iss + PW'(1);
         if (compl)  cmp  <= cmp + PW'(1);
         if (retire) head <= head + PW'(1);
      end
   end

   // entry storage: alloc, issue and completion always touch distinct slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            e_st[i]    <= ST_FREE;
            e_id[i]    <= '0;
            e_we[i]    <= 1'b0;
            e_addr[i]  <= '0;
            e_wdata[i] <= '0;
            e_rd[i]    <= '0;
            e_mode[i]  <= '0;
            e_rdata[i] <= '0;
            e_err[i]   <= 1'b0;
         end
      end else begin
         if (alloc) begin
            e_st[ti]    <= ST_PEND;
            e_id[ti]    <= ls_id;
            e_we[ti]    <= ls_we;
            e_addr[ti]  <= ls_addr;
            e_wdata[ti] <= ls_we ? ls_wdata : '0;
            e_rd[ti]    <= ls_rd;
            e_mode[ti]  <= ls_mode;
         end
         if (issue) e_st[ii] <= ST_ISSUED;
         if (compl) begin
            e_st[ci]    <= ST_DONE;
            e_rdata[ci] <= res_rdata;
            e_err[ci]   <= res_err;
         end
      end
   end

`ifdef RVFPM_MEM_ID_CHECK_EN
   logic unused_res;
   assign unused_res = mem_result[0];

   // sticky protocol error: wrong result id, or a result with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         id_err <= 1'b0;
      else if (mem_result_valid && ((cmp == iss) || (res_id != e_id[ci])))
         id_err <= 1'b1;
   end
`else
   logic unused_res;
   assign unused_res = ^{res_id, mem_result[0]};
   assign id_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rvfpm_mem_ctrl.sv
// Randomized + directed bench for rvfpm_mem_ctrl against a queue-based reference model.
// Honours RVFPM_MEM_ID_CHECK_EN the same way the design does.
module tb_rvfpm_mem_ctrl;

   localparam int DEPTH = 4;
   localparam int REQ_W = 82;
   localparam int RES_W = 38;
`ifdef RVFPM_MEM_ID_CHECK_EN
   localparam bit IDCHK = 1'b1;
`else
   localparam bit IDCHK = 1'b0;
`endif

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             ls_valid = 0, ls_ready, ls_we = 0, kill = 0;
   logic [3:0]       ls_id = '0;
   logic [31:0]      ls_addr = '0, ls_wdata = '0;
   logic [4:0]       ls_rd = '0;
   logic [1:0]       ls_mode = '0;
   logic             mem_valid, mem_ready = 0, mem_result_valid = 0;
   logic [REQ_W-1:0] mem_req;
   logic [RES_W-1:0] mem_result = '0;
   logic             wb_valid, wb_ready = 0, err_valid, id_err;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic [3:0]       wb_id, err_id;
   logic [2:0]       outstanding;

   int passed = 0, total = 0, fails = 0;

   rvfpm_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_id(ls_id), .ls_we(ls_we),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd(ls_rd), .ls_mode(ls_mode),
      .kill(kill), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_result_valid(mem_result_valid), .mem_result(mem_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_id(wb_id), .err_valid(err_valid), .err_id(err_id), .id_err(id_err),
      .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   // reference model: program-order list of live operations
   typedef struct {
      logic [3:0]  id;
      logic        we;
      logic [31:0] addr, wdata, rdata;
      logic [4:0]  rd;
      logic [1:0]  mode;
      bit          issued, done;
      logic        err;
   } ent_t;
   ent_t q[$];
   bit   m_id_err = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int cnt_issued();
      int c = 0;
      foreach (q[i]) if (q[i].issued) c++;
      return c;
   endfunction

   function automatic int first_undone();
      foreach (q[i]) if (!q[i].done) return i;
      return q.size();
   endfunction

   function automatic logic [REQ_W-1:0] pack(input ent_t e);
      return {e.id, e.addr, e.mode, e.we, 3'b010, 4'hF, 2'b00,
              (e.we ? e.wdata : 32'h0), 1'b1, 1'b0};
   endfunction

   task automatic check_outputs();
      int n, u;
      bit hd, werr, wwb;
      n = q.size();
      u = cnt_issued();
      hd   = (n > 0) && q[0].done;
      werr = hd && q[0].err;
      wwb  = hd && !q[0].err && !q[0].we;
      chk("ls_ready", 128'(ls_ready), 128'(n < DEPTH));
      chk("outstanding", 128'(outstanding), 128'(n));
      chk("mem_valid", 128'(mem_valid), 128'(u < n));
      chk("mem_req", 128'(mem_req), (u < n) ? 128'(pack(q[u])) : 128'(0));
      chk("wb_valid", 128'(wb_valid), 128'(wwb));
      chk("wb_rd", 128'(wb_rd), wwb ? 128'(q[0].rd) : 128'(0));
      chk("wb_data", 128'(wb_data), wwb ? 128'(q[0].rdata) : 128'(0));
      chk("wb_id", 128'(wb_id), wwb ? 128'(q[0].id) : 128'(0));
      chk("err_valid", 128'(err_valid), 128'(werr));
      chk("err_id", 128'(err_id), werr ? 128'(q[0].id) : 128'(0));
      chk("id_err", 128'(id_err), 128'(m_id_err));
   endtask

   task automatic model_update();
      int n, u, d;
      bit ret, hs, cm;
      ent_t e;
      n  = q.size();
      u  = cnt_issued();
      d  = first_undone();
      ret = (n > 0) && q[0].done && (q[0].err || q[0].we || wb_ready);
      hs  = (u < n) && mem_ready;
      cm  = mem_result_valid && (d < u);
      if (IDCHK && mem_result_valid && (!cm || mem_result[37:34] != q[d].id)) m_id_err = 1;
      if (cm) begin
         q[d].done  = 1;
         q[d].rdata = mem_result[33:2];
         q[d].err   = mem_result[1];
      end
      if (hs) q[u].issued = 1;
      if (kill) begin
         while (q.size() > (hs ? u + 1 : u)) void'(q.pop_back());
      end else if (ls_valid && n < DEPTH) begin
         e.id = ls_id; e.we = ls_we; e.addr = ls_addr; e.wdata = ls_wdata;
         e.rd = ls_rd; e.mode = ls_mode; e.issued = 0; e.done = 0;
         e.rdata = '0; e.err = 0;
         q.push_back(e);
      end
      if (ret) void'(q.pop_front());
   endtask

   // one clock: check at negedge, advance model at posedge, return just after the edge
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      ls_valid = 0; kill = 0; mem_ready = 0; mem_result_valid = 0; wb_ready = 1;
   endtask

   task automatic set_ls(input logic [3:0] id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
      ls_valid = 1; ls_id = id; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      ls_rd = rd; ls_mode = 2'd3;
   endtask

   task automatic set_res(input logic [3:0] id, input logic [31:0] rdata, input logic err);
      mem_result_valid = 1;
      mem_result = {id, rdata, err, 1'b0};
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      q.delete();
      m_id_err = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
   endtask

   initial begin
      idle();
      #12 rst_n = 1;
      cycle();                               // reset values via model

      // single FLW
      set_ls(4'd3, 1'b0, 32'h100, 32'h55, 5'd3);
      cycle();
      ls_valid = 0;
      chk("flw_mem_valid", 128'(mem_valid), 128'(1));
      chk("flw_we", 128'(mem_req[43]), 128'(0));
      chk("flw_size", 128'(mem_req[42:40]), 128'(2));
      chk("flw_be", 128'(mem_req[39:36]), 128'(4'hF));
      chk("flw_outst1", 128'(outstanding), 128'(1));
      mem_ready = 1; cycle(); mem_ready = 0;
      chk("flw_issued", 128'(mem_valid), 128'(0));
      set_res(4'd3, 32'hDEADBEEF, 1'b0); cycle(); mem_result_valid = 0;
      chk("flw_wb_valid", 128'(wb_valid), 128'(1));
      chk("flw_wb_rd", 128'(wb_rd), 128'(3));
      chk("flw_wb_id", 128'(wb_id), 128'(3));
      chk("flw_wb_data", 128'(wb_data), 128'(32'hDEADBEEF));
      cycle();
      chk("flw_outst0", 128'(outstanding), 128'(0));

      // fill with stores while the bus stalls
      for (int i = 0; i < 4; i++) begin
         set_ls(4'(4 + i), 1'b1, 32'h200 + 32'(4 * i), $urandom, 5'd0);
         cycle();
      end
      ls_valid = 0;
      chk("fill_ready", 128'(ls_ready), 128'(0));
      chk("fill_outst", 128'(outstanding), 128'(4));
      set_ls(4'd15, 1'b0, 32'h0, 32'h0, 5'd1);
      repeat (2) cycle();
      ls_valid = 0;
      chk("fill_hold_id", 128'(mem_req[81:78]), 128'(4));
      mem_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("fill_order_v", 128'(mem_valid), 128'(1));
         chk("fill_order_id", 128'(mem_req[81:78]), 128'(4 + i));
         cycle();
      end
      mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         set_res(4'(4 + i), $urandom, 1'b0); cycle();
      end
      idle(); cycle();
      chk("fill_drained", 128'(outstanding), 128'(0));

      // writeback backpressure
      mem_ready = 1;
      set_ls(4'd1, 1'b0, 32'h300, 32'h0, 5'd7); cycle();
      set_ls(4'd2, 1'b0, 32'h304, 32'h0, 5'd8); cycle();
      ls_valid = 0; cycle(); mem_ready = 0; wb_ready = 0;
      set_res(4'd1, 32'h1111_0001, 1'b0); cycle();
      set_res(4'd2, 32'h2222_0002, 1'b0); cycle();
      mem_result_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_v", 128'(wb_valid), 128'(1));
         chk("bp_hold_id", 128'(wb_id), 128'(1));
         cycle();
      end
      wb_ready = 1;
      chk("bp_first", 128'(wb_data), 128'(32'h1111_0001));
      cycle();
      chk("bp_second_id", 128'(wb_id), 128'(2));
      cycle();
      chk("bp_done", 128'(outstanding), 128'(0));

      // store with bus error
      set_ls(4'd9, 1'b1, 32'h400, 32'hCAFE, 5'd0); cycle();
      ls_valid = 0; mem_ready = 1; cycle(); mem_ready = 0;
      set_res(4'd9, 32'h0, 1'b1); cycle(); mem_result_valid = 0;
      chk("err_pulse", 128'(err_valid), 128'(1));
      chk("err_id_val", 128'(err_id), 128'(9));
      chk("err_no_wb", 128'(wb_valid), 128'(0));
      cycle();
      chk("err_one_cycle", 128'(err_valid), 128'(0));
      chk("err_retired", 128'(outstanding), 128'(0));

      // kill with one entry handshaking in the same cycle
      for (int i = 0; i < 4; i++) begin
         set_ls(4'(10 + i), 1'b0, 32'h500 + 32'(4 * i), 32'h0, 5'(i)); cycle();
      end
      ls_valid = 0; kill = 1; mem_ready = 1; cycle();
      kill = 0; mem_ready = 0;
      chk("kill_outst", 128'(outstanding), 128'(1));
      chk("kill_no_pend", 128'(mem_valid), 128'(0));
      set_res(4'd10, 32'hA5A5, 1'b0); cycle(); mem_result_valid = 0;
      cycle();
      chk("kill_drained", 128'(outstanding), 128'(0));

      // id mismatch: expected id 2, result carries id 5
      set_ls(4'd2, 1'b0, 32'h600, 32'h0, 5'd2); cycle();
      ls_valid = 0; mem_ready = 1; cycle(); mem_ready = 0;
      set_res(4'd5, 32'h77, 1'b0); cycle(); mem_result_valid = 0;
      chk("id_err_set", 128'(id_err), 128'(IDCHK));
      repeat (3) cycle();
      chk("id_err_sticky", 128'(id_err), 128'(IDCHK));

      // stale result after reset is dropped
      do_reset();
      cycle();
      set_res(4'd6, 32'h1, 1'b0); cycle(); mem_result_valid = 0;
      chk("stale_outst", 128'(outstanding), 128'(0));
      chk("stale_id_err", 128'(id_err), 128'(IDCHK));

      // randomized traffic with one reset in the middle
      for (int c = 0; c < 2000; c++) begin
         int u, d;
         if (c == 1000) do_reset();
         ls_valid = $urandom_range(0, 2) != 0;
         ls_id    = 4'($urandom);
         ls_we    = 1'($urandom);
         ls_addr  = $urandom;
         ls_wdata = $urandom;
         ls_rd    = 5'($urandom);
         ls_mode  = 2'($urandom);
         mem_ready = $urandom_range(0, 3) != 0;
         wb_ready  = $urandom_range(0, 3) != 0;
         kill      = $urandom_range(0, 19) == 0;
         u = cnt_issued();
         d = first_undone();
         if (d < u && $urandom_range(0, 9) < 6)
            set_res(q[d].id, $urandom, $urandom_range(0, 7) == 0);
         else if ($urandom_range(0, 39) == 0)
            set_res(4'($urandom), $urandom, 1'($urandom));
         else
            mem_result_valid = 0;
         cycle();
      end

      idle();
      repeat (3) cycle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
